vend_dispenser: RTL and testbench

- Output-side controller for the coin-operated vending FSM. It consumes that FSM's `dispensed`/`change` indications and drives the product motor and the 5-unit change-coin ejector with timed pulses.
- Sits between the vending FSM and the physical actuators.
- Buffers one request while busy, so back-to-back vends are not lost.

---
 rtl/vend_pkg.sv | 33 +++
 rtl/vend_pulse_timer.sv | 30 +++
 rtl/vend_dispenser.sv | 218 +++++++++++++++++++++
 tb/tb_vend_dispenser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine: dispenser state encoding, coin values
// and a small constant helper used for sizing counters.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEND  = 3'd1,
    GAP   = 3'd2,
    EJECT = 3'd3,
    DONE  = 3'd4
  } vend_state_e;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int PRICE   = 15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter with terminal-count flag; reloaded at the start of every
// dispenser phase and holds at zero instead of wrapping.
module vend_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count down to zero and stay there until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/vend_dispenser.sv
// Output-side vending controller: timed motor pulse, optional gap + change-coin pulse,
// one-deep request buffer. Define STOCK_COUNT_EN to add restock/sold_out stock tracking.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int EJECT_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
`ifdef STOCK_COUNT_EN
  ,
  parameter int STOCK_INIT   = 10
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic dispensed,
  input  logic change,
`ifdef STOCK_COUNT_EN
  input  logic restock,
  output logic sold_out,
`endif
  output logic motor_on,
  output logic coin_eject,
  output logic busy,
  output logic done,
  output logic overflow
);

  localparam int TW = $clog2(max3(MOTOR_CYCLES, EJECT_CYCLES, GAP_CYCLES) + 1);

  vend_state_e   state_r, next_state_s;
  logic          chg_r, start_s, start_chg_s;
  logic          pend_valid_r, pend_valid_s, pend_chg_r, pend_chg_s;
  logic          overflow_r, overflow_s;
  logic          req_s, stock_ok_s;
  logic          load_s, tc_s;
  logic [TW-1:0] load_val_s;
  logic          motor_on_r, coin_eject_r, busy_r, done_r;
  logic          motor_on_s, coin_eject_s, busy_s, done_s;

`ifdef STOCK_COUNT_EN
  localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [SW-1:0] stock_r, stock_s;
  logic          sold_out_r;

  // Restock wins over a same-cycle VEND entry, but that entry still consumes one unit
  always_comb begin
    stock_s = stock_r;
    if (restock) begin
      if (start_s) begin
        stock_s = SW'(STOCK_INIT - 1);
      end else begin
        stock_s = SW'(STOCK_INIT);
      end
    end else if (start_s) begin
      stock_s = stock_r - SW'(1);
    end else begin
      stock_s = stock_r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stock_r    <= SW'(STOCK_INIT);
      sold_out_r <= (STOCK_INIT == 0);
    end else begin
      stock_r    <= stock_s;
      sold_out_r <= (stock_s == {SW{1'b0}});
    end
  end

  assign req_s      = dispensed & ~sold_out_r;
  assign stock_ok_s = ~sold_out_r;
  assign sold_out   = sold_out_r;
`else
  assign req_s      = dispensed;
  assign stock_ok_s = 1'b1;
`endif

  // State, captured change flag, pending slot and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      chg_r        <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_chg_r   <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      chg_r        <= start_chg_s;
      pend_valid_r <= pend_valid_s;
      pend_chg_r   <= pend_chg_s;
      overflow_r   <= overflow_s;
    end
  end

  // A pending request is served before a newly arriving one
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    start_chg_s  = chg_r;
    case (state_r)
      IDLE: begin
        if (pend_valid_r) begin
          if (stock_ok_s) begin
            next_state_s = VEND;
            start_s      = 1'b1;
            start_chg_s  = pend_chg_r;
          end else begin
            next_state_s = IDLE;
          end
        end else if (req_s) begin
          next_state_s = VEND;
          start_s      = 1'b1;
          start_chg_s  = change;
        end else begin
          next_state_s = IDLE;
        end
      end
      VEND: begin
        if (tc_s) begin
          next_state_s = chg_r ? GAP : DONE;
        end else begin
          next_state_s = VEND;
        end
      end
      GAP: begin
        if (tc_s) begin
          next_state_s = EJECT;
        end else begin
          next_state_s = GAP;
        end
      end
      EJECT: begin
        if (tc_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = EJECT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  always_comb begin
    pend_valid_s = pend_valid_r;
    pend_chg_s   = pend_chg_r;
    overflow_s   = overflow_r;
    if (state_r == IDLE) begin
      if (start_s && pend_valid_r) begin
        pend_valid_s = req_s;
        pend_chg_s   = change;
      end else begin
        pend_valid_s = pend_valid_r;
      end
    end else if (req_s) begin
      if (pend_valid_r) begin
        overflow_s = 1'b1;
      end else begin
        pend_valid_s = 1'b1;
        pend_chg_s   = change;
      end
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // Each phase reloads the timer with its length minus one; tc marks the last cycle
  always_comb begin
    load_s = (next_state_s != state_r);
    case (next_state_s)
      VEND:    load_val_s = TW'(MOTOR_CYCLES - 1);
      GAP:     load_val_s = TW'(GAP_CYCLES - 1);
      EJECT:   load_val_s = TW'(EJECT_CYCLES - 1);
      default: load_val_s = {TW{1'b0}};
    endcase
  end

  vend_pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  always_comb begin
    motor_on_s   = (next_state_s == VEND);
    coin_eject_s = (next_state_s == EJECT);
    done_s       = (next_state_s == DONE);
    busy_s       = (next_state_s != IDLE) | pend_valid_s;
  end

  // Outputs registered from the next state so they line up with the state itself
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_on_r   <= 1'b0;
      coin_eject_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      motor_on_r   <= motor_on_s;
      coin_eject_r <= coin_eject_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign motor_on   = motor_on_r;
  assign coin_eject = coin_eject_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser: each accepted request pushes its expected
// motor start cycle and change flag; every done pulse pops and checks the phase timing.
module tb_vend_dispenser;

  localparam int M = 8;
  localparam int E = 4;
  localparam int G = 2;

  typedef struct {
    logic chg;
    int   start;
  } exp_t;

  logic clk = 1'b0;
  logic reset, dispensed, change;
  logic motor_on, coin_eject, busy, done, overflow;
`ifdef STOCK_COUNT_EN
  logic restock, sold_out;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -100;
  int   done_cnt = 0;
  exp_t sb[$];

  vend_dispenser #(
    .MOTOR_CYCLES (M),
    .EJECT_CYCLES (E),
    .GAP_CYCLES   (G)
`ifdef STOCK_COUNT_EN
    ,
    .STOCK_INIT   (1)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dispensed  (dispensed),
    .change     (change),
`ifdef STOCK_COUNT_EN
    .restock    (restock),
    .sold_out   (sold_out),
`endif
    .motor_on   (motor_on),
    .coin_eject (coin_eject),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one request in the current cycle; if it should run, queue its expected start
  task automatic send(input logic chg, input bit runs);
    int s;
    dispensed = 1'b1;
    change    = chg;
    if (runs) begin
      s = (cyc + 1 > last_done + 2) ? cyc + 1 : last_done + 2;
      sb.push_back('{chg, s});
      last_done = s + M + (chg ? G + E : 0);
    end
    @(negedge clk);
    dispensed = 1'b0;
    change    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq({tag, "_busy_clear"}, int'(busy), 0);
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: measure each transaction and compare it against the scoreboard on done
  initial begin
    logic prev_motor, prev_eject, in_txn;
    int   m_start, m_cnt, e_cnt, e_start, busy_drop;
    exp_t e;
    prev_motor = 1'b0; prev_eject = 1'b0; in_txn = 1'b0;
    m_start = 0; m_cnt = 0; e_cnt = 0; e_start = 0; busy_drop = 0;
    forever begin
      @(negedge clk);
      if (motor_on && !prev_motor) begin
        m_start = cyc; m_cnt = 0; e_cnt = 0; e_start = -1; busy_drop = 0; in_txn = 1'b1;
      end
      if (motor_on) m_cnt = m_cnt + 1;
      if (coin_eject) begin
        if (!prev_eject) e_start = cyc;
        e_cnt = e_cnt + 1;
      end
      if (in_txn && !busy) busy_drop = busy_drop + 1;
      if (motor_on && coin_eject) check_eq("motor_eject_overlap", 1, 0);
      if (done) begin
        done_cnt = done_cnt + 1;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("motor_start", m_start, e.start);
          check_eq("motor_len", m_cnt, M);
          check_eq("eject_len", e_cnt, e.chg ? E : 0);
          if (e.chg) check_eq("gap_len", e_start - (m_start + m_cnt), G);
          check_eq("done_cycle", cyc, e.start + M + (e.chg ? G + E : 0));
          check_eq("busy_throughout", busy_drop, 0);
        end
        in_txn = 1'b0;
      end
      prev_motor = motor_on;
      prev_eject = coin_eject;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, n, motor_seen;
    reset = 1'b0; dispensed = 1'b0; change = 1'b0;
`ifdef STOCK_COUNT_EN
    restock = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_motor", int'(motor_on), 0);
    check_eq("rst_eject", int'(coin_eject), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef STOCK_COUNT_EN
    check_eq("stock_init_sold_out", int'(sold_out), 0);
    send(1'b0, 1'b1);
    check_eq("stock_sold_out_after_vend", int'(sold_out), 1);
    @(negedge clk);
    send(1'b0, 1'b0);
    check_eq("stock_no_overflow", int'(overflow), 0);
    drain("stock_first");
    check_eq("stock_still_sold_out", int'(sold_out), 1);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    check_eq("stock_restocked", int'(sold_out), 0);
    send(1'b0, 1'b1);
    check_eq("stock_motor_runs", int'(motor_on), 1);
    drain("stock_second");
`else
    // Single vend without change, then with change
    send(1'b0, 1'b1);
    check_eq("latency_motor", int'(motor_on), 1);
    check_eq("latency_busy", int'(busy), 1);
    drain("single");
    send(1'b1, 1'b1);
    drain("with_change");

    // change without dispensed is ignored
    change = 1'b1;
    repeat (3) @(negedge clk);
    change = 1'b0;
    @(negedge clk);
    check_eq("change_alone_busy", int'(busy), 0);
    check_eq("change_alone_motor", int'(motor_on), 0);

    // Second request three cycles into the first goes through pending
    send(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    send(1'b0, 1'b1);
    drain("pending");
    check_eq("pending_no_overflow", int'(overflow), 0);

    // Requests landing on the DONE cycle and on the following IDLE cycle
    send(1'b0, 1'b1);
    wait_cycle(last_done);
    check_eq("at_done_pulse", int'(done), 1);
    send(1'b0, 1'b1);
    drain("req_at_done");
    d0 = last_done;
    wait_cycle(d0 + 1);
    send(1'b1, 1'b1);
    drain("req_after_done");

    // Three back-to-back requests: the third is dropped
    d0 = done_cnt;
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    check_eq("overflow_set", int'(overflow), 1);
    drain("triple");
    check_eq("triple_done_pulses", done_cnt - d0, 2);
    check_eq("overflow_sticky", int'(overflow), 1);

    // Reset during the eject phase with a request pending
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    n = 0;
    while (!coin_eject && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq("eject_reached", int'(coin_eject), 1);
    reset = 1'b0;
    #1;
    check_eq("midrst_eject", int'(coin_eject), 0);
    check_eq("midrst_motor", int'(motor_on), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    check_eq("midrst_overflow", int'(overflow), 0);
    sb.delete();
    last_done = -100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    motor_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (motor_on || coin_eject || busy) motor_seen = motor_seen + 1;
    end
    check_eq("pending_discarded", motor_seen, 0);
`endif

    check_eq("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
